// File: rtl/zle_arb2.sv
// zle_arb2: two-requester arbiter in front of one shared ZLE encoder; grants move only when no zero run is open.
// Optional burst limit on a grant is compiled in with `define ZLE_ARB_BURST_EN.
module zle_arb2 #(
  parameter int unsigned BURST  = 8,
  parameter int unsigned PCNT_W = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] a_d,
  input  logic       a_v,
  output logic       a_b,
  input  logic [2:0] b_d,
  input  logic       b_v,
  output logic       b_b,
  output logic [2:0] e_i_d,
  output logic       e_i_v,
  input  logic       e_i_b,
  input  logic [3:0] e_o_d,
  input  logic       e_o_v,
  output logic       e_o_b,
  output logic [3:0] ao_d,
  output logic       ao_v,
  input  logic       ao_b,
  output logic [3:0] bo_d,
  output logic       bo_v,
  input  logic       bo_b
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, DRAIN} state_t;
  typedef enum logic [1:0] {O_NONE, O_A, O_B} owner_t;

  state_t            state, state_nx;
  owner_t            owner, last;
  logic [PCNT_W-1:0] pcnt;
  logic              zflag;
  logic              stall, burst_hit, owning, cur_v, oth_v, yield, enter;
  logic              acc_in, in_nz, lit_out;

  assign stall   = (pcnt == '1);
  assign owning  = (state == OWN_A) || (state == OWN_B);
  assign cur_v   = (state == OWN_A) ? a_v : b_v;
  assign oth_v   = (state == OWN_A) ? b_v : a_v;
  assign acc_in  = e_i_v & ~e_i_b;
  assign in_nz   = acc_in & (e_i_d != '0);
  assign lit_out = e_o_v & ~e_o_b & ~e_o_d[3];
  // Registered zflag keeps a yield from ever splitting an open zero run.
  assign yield   = owning & oth_v & ~zflag & (~cur_v | burst_hit);
  assign enter   = ((state == IDLE) || (state == DRAIN)) &&
                   ((state_nx == OWN_A) || (state_nx == OWN_B));

`ifdef ZLE_ARB_BURST_EN
  localparam int unsigned BCNT_W = $clog2(BURST + 1);
  logic [BCNT_W-1:0] bcnt;

  assign burst_hit = (bcnt == BCNT_W'(BURST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt <= '0;
    end else if (enter) begin
      bcnt <= '0;
    end else if (in_nz && !burst_hit) begin
      bcnt <= bcnt + 1'b1;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (a_v && (!b_v || last == O_B)) begin
          state_nx = OWN_A;
        end else if (b_v) begin
          state_nx = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (yield) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pcnt == '0) begin
          state_nx = (owner == O_A) ? OWN_B : OWN_A;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_b   = 1'b1;
    b_b   = 1'b1;
    e_i_v = 1'b0;
    e_i_d = '0;
    unique case (state)
      OWN_A: begin
        e_i_d = a_d;
        e_i_v = a_v & ~stall;
        a_b   = e_i_b | stall;
      end
      OWN_B: begin
        e_i_d = b_d;
        e_i_v = b_v & ~stall;
        b_b   = e_i_b | stall;
      end
      default: ;
    endcase

    ao_d  = e_o_d;
    bo_d  = e_o_d;
    ao_v  = 1'b0;
    bo_v  = 1'b0;
    e_o_b = 1'b1;
    unique case (owner)
      O_A: begin
        ao_v  = e_o_v;
        e_o_b = ao_b;
      end
      O_B: begin
        bo_v  = e_o_v;
        e_o_b = bo_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner <= O_NONE;
      last  <= O_B;
      pcnt  <= '0;
      zflag <= 1'b0;
    end else begin
      if (in_nz && !lit_out && !stall) begin
        pcnt <= pcnt + 1'b1;
      end else if (!in_nz && lit_out && pcnt != '0) begin
        pcnt <= pcnt - 1'b1;
      end

      if (enter) begin
        owner <= (state_nx == OWN_A) ? O_A : O_B;
        last  <= (state_nx == OWN_A) ? O_A : O_B;
        zflag <= 1'b0;
      end else if (acc_in) begin
        zflag <= (e_i_d == '0);
      end
    end
  end

endmodule

// File: tb/tb_zle_arb2.sv
// Bench for zle_arb2: behavioural stand-in encoder, token producers/sinks, and an output scoreboard.
module tb_zle_arb2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] a_d = '0, b_d = '0;
  logic       a_v = 1'b0, b_v = 1'b0;
  logic       a_b, b_b;
  logic [2:0] e_i_d;
  logic       e_i_v;
  logic       e_i_b = 1'b0;
  logic [3:0] e_o_d = '0;
  logic       e_o_v = 1'b0;
  logic       e_o_b;
  logic [3:0] ao_d, bo_d;
  logic       ao_v, bo_v;
  logic       ao_b = 1'b0, bo_b = 1'b0;

  zle_arb2 #(.BURST(8), .PCNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .a_d(a_d), .a_v(a_v), .a_b(a_b),
    .b_d(b_d), .b_v(b_v), .b_b(b_b),
    .e_i_d(e_i_d), .e_i_v(e_i_v), .e_i_b(e_i_b),
    .e_o_d(e_o_d), .e_o_v(e_o_v), .e_o_b(e_o_b),
    .ao_d(ao_d), .ao_v(ao_v), .ao_b(ao_b),
    .bo_d(bo_d), .bo_v(bo_v), .bo_b(bo_b)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] qa[$], qb[$];
  logic [3:0] eq[$];
  logic [3:0] exp_a[$], exp_b[$];
  int         run = 0;
  int         ca = 0;
  int         ca_at_b = -1;
  int         bb_low = 0;
  bit         watch_bb = 0, chk_order = 0;
  bit         hold_ao = 0, hold_bo = 0;
  bit         f_a = 0, f_b = 0, f_ei = 0, f_eo = 0;
  logic [2:0] ei_s = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Driver and stand-in encoder: apply last edge's transfers, drive, then latch what the next edge transfers.
  always @(negedge clock) begin
    if (f_a) begin qa.delete(0); ca++; end
    if (f_b) qb.delete(0);
    if (f_eo) eq.delete(0);
    if (f_ei) begin
      if (ei_s == 3'd0) begin
        run++;
        if (run == 7) begin eq.push_back(4'b1111); run = 0; end
      end else begin
        if (run != 0) begin eq.push_back({1'b1, 3'(run)}); run = 0; end
        eq.push_back({1'b0, ei_s});
      end
    end
    a_v   = (qa.size() != 0);
    a_d   = (qa.size() != 0) ? qa[0] : 3'd0;
    b_v   = (qb.size() != 0);
    b_d   = (qb.size() != 0) ? qb[0] : 3'd0;
    e_o_v = (eq.size() != 0);
    e_o_d = (eq.size() != 0) ? eq[0] : 4'd0;
    e_i_b = (eq.size() >= 12);
    ao_b  = hold_ao;
    bo_b  = hold_bo;
    #1;
    f_a  = a_v & ~a_b;
    f_b  = b_v & ~b_b;
    f_ei = e_i_v & ~e_i_b;
    ei_s = e_i_d;
    f_eo = e_o_v & ~e_o_b;
    if (watch_bb && !b_b) bb_low++;
    if (f_b && ca_at_b < 0) ca_at_b = ca;
    if (chk_order && f_b) chk("b_token_after_a_drained", exp_a.size(), 0);
  end

  // Scoreboard monitor: every transfer on a return stream pops that stream's expectation.
  always @(negedge clock) begin
    #2;
    if (ao_v && !ao_b) begin
      if (exp_a.size() == 0) chk("ao_unexpected", {28'd0, ao_d}, 32'hFFFF);
      else begin chk("ao_data", {28'd0, ao_d}, {28'd0, exp_a[0]}); exp_a.delete(0); end
    end
    if (bo_v && !bo_b) begin
      if (exp_b.size() == 0) chk("bo_unexpected", {28'd0, bo_d}, 32'hFFFF);
      else begin chk("bo_data", {28'd0, bo_d}, {28'd0, exp_b[0]}); exp_b.delete(0); end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clock);
    #3;
  endtask

  task automatic clear_all();
    qa.delete(); qb.delete(); eq.delete(); exp_a.delete(); exp_b.delete();
    run = 0; ca = 0; ca_at_b = -1; bb_low = 0;
    watch_bb = 0; chk_order = 0; hold_ao = 0; hold_bo = 0;
    f_a = 0; f_b = 0; f_ei = 0; f_eo = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_all();
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(input string nm);
    int unsigned n = 0;
    while ((qa.size() + qb.size() + exp_a.size() + exp_b.size()) != 0 && n < 300) begin
      tick(1);
      n++;
    end
    chk({nm, "_drained"}, qa.size() + qb.size() + exp_a.size() + exp_b.size(), 0);
    tick(2);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_a_b"}, a_b, 1);
    chk({nm, "_b_b"}, b_b, 1);
    chk({nm, "_e_i_v"}, e_i_v, 0);
    chk({nm, "_ao_v"}, ao_v, 0);
    chk({nm, "_bo_v"}, bo_v, 0);
    chk({nm, "_e_o_b"}, e_o_b, 1);
  endtask

  initial begin
    logic [2:0] d;
    tick(1);
    chk_reset_outputs("rst");
    apply_reset();

    // A sends 0,0,3 alone: one count then literal 3 on ao; B never granted.
    watch_bb = 1;
    qa.push_back(3'd0); qa.push_back(3'd0); qa.push_back(3'd3);
    exp_a.push_back(4'b1010); exp_a.push_back(4'b0011);
    tick(1);
    chk("t1_idle_a_b", a_b, 1);
    tick(1);
    chk("t1_grant_a_b", a_b, 0);
    chk("t1_grant_e_i_v", e_i_v, 1);
    wait_done("t1");
    chk("t1_b_b_held", bb_low, 0);

    // Tie from IDLE: A first, B only after all of A's literals have left.
    apply_reset();
    chk_order = 1;
    qa.push_back(3'd1); qa.push_back(3'd2); qa.push_back(3'd3);
    qb.push_back(3'd4); qb.push_back(3'd5);
    exp_a.push_back(4'b0001); exp_a.push_back(4'b0010); exp_a.push_back(4'b0011);
    exp_b.push_back(4'b0100); exp_b.push_back(4'b0101);
    tick(2);
    chk("t2_tie_a_b", a_b, 0);
    chk("t2_tie_b_b", b_b, 1);
    wait_done("t2");
    chk_order = 0;

    // Open run: A sends 0,0 and goes quiet; grant must hold until A closes it with 5.
    apply_reset();
    qa.push_back(3'd0); qa.push_back(3'd0);
    qb.push_back(3'd6);
    exp_a.push_back(4'b1010); exp_a.push_back(4'b0101);
    exp_b.push_back(4'b0110);
    tick(10);
    chk("t3_hold_a_b", a_b, 0);
    chk("t3_hold_b_b", b_b, 1);
    chk("t3_hold_b_pending", qb.size(), 1);
    qa.push_back(3'd5);
    wait_done("t3");

    // Return path blocked: seven literals in flight stall A, then everything flows on release.
    apply_reset();
    hold_ao = 1;
    for (int unsigned i = 0; i < 10; i++) begin
      d = 3'((i % 7) + 1);
      qa.push_back(d);
      exp_a.push_back({1'b0, d});
    end
    tick(20);
    chk("t4_accepted_at_stall", ca, 7);
    chk("t4_stall_a_b", a_b, 1);
    chk("t4_stall_e_i_v", e_i_v, 0);
    hold_ao = 0;
    wait_done("t4");
    chk("t4_accepted_total", ca, 10);

`ifdef ZLE_ARB_BURST_EN
    // Burst limit: A continuously valid must still hand over to B before finishing.
    apply_reset();
    for (int unsigned i = 0; i < 12; i++) begin
      d = 3'((i % 7) + 1);
      qa.push_back(d);
      exp_a.push_back({1'b0, d});
    end
    qb.push_back(3'd6); qb.push_back(3'd7);
    exp_b.push_back(4'b0110); exp_b.push_back(4'b0111);
    wait_done("t5");
    chk("t5_burst_yield", (ca_at_b >= 8 && ca_at_b < 12), 1);
`endif

    // Reset while draining: outputs return to reset values at once, next tie goes to A.
    apply_reset();
    hold_ao = 1;
    qa.push_back(3'd1);
    qb.push_back(3'd2);
    tick(8);
    chk("t6_drain_a_b", a_b, 1);
    chk("t6_drain_b_b", b_b, 1);
    chk("t6_drain_ao_v", ao_v, 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    clear_all();
    tick(2);
    reset = 1'b1;
    tick(1);
    qa.push_back(3'd3); qb.push_back(3'd4);
    exp_a.push_back(4'b0011); exp_b.push_back(4'b0100);
    tick(2);
    chk("t6_tie_a_b", a_b, 0);
    chk("t6_tie_b_b", b_b, 1);
    wait_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    $fatal(1);
  end

endmodule
